drum_pitch_sweep: RTL and testbench

// - Per-pad voice controller that sits directly upstream of the PWM tone generator.
// - Drives its 16-bit period input (top) and a tone gate.
// - On a pad hit: loads a start period, holds it for a fixed number of ticks, then

---
 rtl/drum_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/drum_pitch_sweep.sv | 116 +++++++++++
 tb/tb_drum_pitch_sweep.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and constants for the drum voice blocks.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } voice_state_t;

    localparam int PERIOD_W         = 16;
    localparam int TICK_DIV_DEFAULT = 50000;

endpackage : drum_pkg

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
    parameter int DIV = drum_pkg::TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    // Tick is decoded from the count so it lines up with the wrap cycle.
    assign tick = en && !clr && (count_q == LAST);

    // Count while enabled; a clear or a disable parks the count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr || !en) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule : tick_prescaler

// File: rtl/drum_pitch_sweep.sv
// Per-pad voice controller: hold a start period, then ramp it to an end period.
module drum_pitch_sweep
    import drum_pkg::*;
#(
    parameter int PERIOD_W     = drum_pkg::PERIOD_W,
    parameter int START_PERIOD = 2000,
    parameter int END_PERIOD   = 6000,
    parameter int SWEEP_STEP   = 8,
    parameter int TICK_DIV     = drum_pkg::TICK_DIV_DEFAULT,
    parameter int HOLD_TICKS   = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit,
    output logic [PERIOD_W-1:0] top,
    output logic                tone_en,
    output logic                busy,
    output logic                done
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [PERIOD_W-1:0] START_P   = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W:0]   END_P     = (PERIOD_W + 1)'(END_PERIOD);
    localparam logic [PERIOD_W:0]   STEP_P    = (PERIOD_W + 1)'(SWEEP_STEP);

    voice_state_t        state_q;
    logic                hit_q;
    logic [HW-1:0]       hold_cnt_q;
    logic [PERIOD_W-1:0] top_q;
    logic                tone_en_q;
    logic                done_q;

    logic                strike;
    logic                tick;
    logic [PERIOD_W:0]   sum_d;

    assign strike = hit && !hit_q;
    assign busy   = (state_q != IDLE);

    // The carry bit keeps the termination compare honest near the top of range.
    assign sum_d = {1'b0, top_q} + STEP_P;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (strike),
        .en   (busy),
        .tick (tick)
    );

    // Remember the previous hit level so only rising edges strike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit;
        end
    end

    // Voice FSM with period datapath; a strike overrides any tick activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            top_q      <= START_P;
            tone_en_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (strike) begin
                state_q    <= HOLD;
                hold_cnt_q <= '0;
                top_q      <= START_P;
                tone_en_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        tone_en_q <= 1'b0;
                    end
                    HOLD: begin
                        if (tick) begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                state_q <= SWEEP;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + 1'b1;
                            end
                        end
                    end
                    SWEEP: begin
                        if (tick) begin
                            if (sum_d >= END_P) begin
                                top_q     <= END_P[PERIOD_W-1:0];
                                tone_en_q <= 1'b0;
                                done_q    <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                top_q <= sum_d[PERIOD_W-1:0];
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign top     = top_q;
    assign tone_en = tone_en_q;
    assign done    = done_q;

endmodule : drum_pitch_sweep

// File: tb/tb_drum_pitch_sweep.sv
// Directed bench for drum_pitch_sweep with a short tick and small periods.
module tb_drum_pitch_sweep;
    import drum_pkg::*;

    logic        clk;
    logic        rst;
    logic        hit;
    logic [15:0] top;
    logic        tone_en;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    drum_pitch_sweep #(
        .START_PERIOD (100),
        .END_PERIOD   (250),
        .SWEEP_STEP   (50),
        .TICK_DIV     (4),
        .HOLD_TICKS   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hit     (hit),
        .top     (top),
        .tone_en (tone_en),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise hit, land half a cycle after the strike update edge (t=0), drop hit.
    task automatic strike_pulse();
        hit = 1'b1;
        adv(1);
        hit = 1'b0;
    endtask

    initial begin
        int dcnt;
        int maxtop;
        rst = 1'b1;
        hit = 1'b0;

        // 1. reset held while hit toggles
        for (int i = 0; i < 6; i++) begin
            hit = i[0];
            adv(1);
            check("rst_top", 32'(top), 100);
            check("rst_tone", 32'(tone_en), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
        end
        hit = 1'b0;
        adv(1);
        rst = 1'b0;
        adv(2);
        check("idle_busy", 32'(busy), 0);

        // 2. full sweep
        strike_pulse();
        check("t0_top", 32'(top), 100);
        check("t0_tone", 32'(tone_en), 1);
        check("t0_busy", 32'(busy), 1);
        check("t0_done", 32'(done), 0);
        adv(7);
        check("t7_state", 32'(dut.state_q), 32'(HOLD));
        adv(1);
        check("t8_state", 32'(dut.state_q), 32'(SWEEP));
        check("t8_top", 32'(top), 100);
        adv(3);
        check("t11_top", 32'(top), 100);
        adv(1);
        check("t12_top", 32'(top), 150);
        adv(4);
        check("t16_top", 32'(top), 200);
        adv(3);
        check("t19_done", 32'(done), 0);
        check("t19_busy", 32'(busy), 1);
        adv(1);
        check("t20_top", 32'(top), 250);
        check("t20_tone", 32'(tone_en), 0);
        check("t20_busy", 32'(busy), 0);
        check("t20_done", 32'(done), 1);
        adv(1);
        check("t21_done", 32'(done), 0);
        check("t21_top", 32'(top), 250);
        adv(3);

        // 3. retrigger at t=14
        strike_pulse();
        adv(13);
        check("rt_t13_top", 32'(top), 150);
        hit = 1'b1;
        adv(1);
        hit = 1'b0;
        check("rt_t14_top", 32'(top), 100);
        check("rt_t14_busy", 32'(busy), 1);
        check("rt_t14_done", 32'(done), 0);
        dcnt = 0;
        for (int i = 0; i < 19; i++) begin
            adv(1);
            dcnt += int'(done);
        end
        check("rt_no_early_done", 32'(dcnt), 0);
        adv(1);
        check("rt_t34_done", 32'(done), 1);
        check("rt_t34_top", 32'(top), 250);
        adv(3);

        // 4. hit held high for 40 cycles
        hit = 1'b1;
        dcnt = 0;
        maxtop = 0;
        for (int i = 0; i < 40; i++) begin
            adv(1);
            if (i == 0) check("held_t0_top", 32'(top), 100);
            dcnt += int'(done);
            if (int'(top) > maxtop) maxtop = int'(top);
        end
        check("held_done_count", 32'(dcnt), 1);
        check("held_busy_end", 32'(busy), 0);
        check("held_top_end", 32'(top), 250);
        check("held_max_top", 32'(maxtop), 250);
        hit = 1'b0;
        adv(2);
        check("held_release_busy", 32'(busy), 0);

        // 5. strike coincident with the terminating tick
        strike_pulse();
        adv(19);
        check("col_t19_top", 32'(top), 200);
        hit = 1'b1;
        adv(1);
        hit = 1'b0;
        check("col_t20_top", 32'(top), 100);
        check("col_t20_tone", 32'(tone_en), 1);
        check("col_t20_done", 32'(done), 0);
        check("col_t20_busy", 32'(busy), 1);
        adv(20);
        check("col_t40_done", 32'(done), 1);
        adv(3);

        // 6. async reset mid-sweep
        strike_pulse();
        adv(12);
        check("ar_t12_top", 32'(top), 150);
        #2;
        rst = 1'b1;
        #1;
        check("ar_top", 32'(top), 100);
        check("ar_tone", 32'(tone_en), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        adv(1);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            dcnt += int'(done) + int'(busy);
        end
        check("ar_quiet_after", 32'(dcnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_drum_pitch_sweep
